// File: rtl/depthwise_conv_stream.sv
// Streaming depthwise KxK convolution, one kernel per channel, result 2 ce-enabled cycles after the completing pixel.
// No backpressure: every accepted pixel is consumed; ce low freezes all state and masks vld/end.
module depthwise_conv_stream #(
    parameter int N             = 16,
    parameter int INPUT_CHANNEL = 3,
    parameter int INPUT_SIZE    = 6,
    parameter int KERNEL_SIZE   = 3,
    parameter int STRIDE        = 1,
    parameter int PADDING       = 0,
    parameter int DILATION      = 1
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              ce,
    input  logic                                              input_vld,
    input  logic [INPUT_CHANNEL*N-1:0]                        input_din,
    input  logic [INPUT_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*N-1:0] weight_din,
    input  logic [INPUT_CHANNEL*32-1:0]                       bias_din,
    input  logic [INPUT_CHANNEL*5-1:0]                        shift_din,
    output logic [INPUT_CHANNEL*N-1:0]                        conv_dout,
    output logic                                              conv_dout_vld,
    output logic                                              conv_dout_end
);

    localparam int C        = INPUT_CHANNEL;
    localparam int K        = KERNEL_SIZE;
    localparam int KK       = K * K;
    localparam int D        = DILATION;
    localparam int KD       = D * (K - 1);
    localparam int DEPTH    = KD * INPUT_SIZE + KD + 1;
    localparam int OUT_SIZE = (INPUT_SIZE - KD - 1) / STRIDE + 1;
    localparam int LAST     = KD + (OUT_SIZE - 1) * STRIDE;
    localparam int CW       = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int SMAX     = (1 << (N - 1)) - 1;
    localparam int SMIN     = -(1 << (N - 1));

    localparam logic [CW-1:0] KD_C   = CW'(KD);
    localparam logic [CW-1:0] LAST_C = CW'(LAST);
    localparam logic [CW-1:0] MAX_C  = CW'(INPUT_SIZE - 1);
    localparam logic [CW-1:0] STR_C  = CW'(STRIDE);

    // Padding is applied upstream; the parameter only documents the frame geometry.
    if (PADDING < 0) begin : g_padding_unused
    end

    logic [CW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic [C*N-1:0]        r_sr [DEPTH-1];
    logic signed [31:0]    r_prod [C][KK];
    logic                  r_v1;
    logic                  r_e1;
    logic                  r_vld;
    logic                  r_end;
    logic [C*N-1:0]        r_dout;

    logic                  w_take;
    logic                  w_win_vld;
    logic                  w_last;
    logic [C*N-1:0]        w_win [DEPTH];
    logic signed [31:0]    w_prod [C][KK];
    logic [C*N-1:0]        w_res;

    assign w_take    = ce & input_vld;
    assign w_win_vld = (r_row >= KD_C) && (r_col >= KD_C) &&
                       (((r_row - KD_C) % STR_C) == '0) && (((r_col - KD_C) % STR_C) == '0);
    assign w_last    = w_win_vld && (r_row == LAST_C) && (r_col == LAST_C);

    // Index 0 is the pixel being accepted now, so the window completes in the same cycle.
    always_comb begin
        w_win[0] = input_din;
        for (int i = 1; i < DEPTH; i++) begin
            w_win[i] = r_sr[i-1];
        end
    end

    always_comb begin
        for (int c = 0; c < C; c++) begin
            for (int ky = 0; ky < K; ky++) begin
                for (int kx = 0; kx < K; kx++) begin
                    w_prod[c][ky*K+kx] =
                        32'($signed(w_win[DEPTH-1-(ky*INPUT_SIZE+kx)*D][c*N +: N])) *
                        32'($signed(weight_din[(c*KK+ky*K+kx)*N +: N]));
                end
            end
        end
    end

    always_comb begin
        logic signed [31:0] v_acc;
        logic signed [31:0] v_shf;
        w_res = '0;
        for (int c = 0; c < C; c++) begin
            v_acc = $signed(bias_din[c*32 +: 32]);
            for (int t = 0; t < KK; t++) begin
                v_acc = v_acc + r_prod[c][t];
            end
            v_shf = v_acc >>> shift_din[c*5 +: 5];
            if (v_shf > SMAX) begin
                w_res[c*N +: N] = N'(SMAX);
            end else if (v_shf < SMIN) begin
                w_res[c*N +: N] = N'(SMIN);
            end else begin
                w_res[c*N +: N] = N'(v_shf);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_row <= '0;
            r_col <= '0;
            for (int i = 0; i < DEPTH-1; i++) begin
                r_sr[i] <= '0;
            end
        end else if (w_take) begin
            r_sr[0] <= input_din;
            for (int i = 1; i < DEPTH-1; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
            if (r_col == MAX_C) begin
                r_col <= '0;
                r_row <= (r_row == MAX_C) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_v1   <= 1'b0;
            r_e1   <= 1'b0;
            r_vld  <= 1'b0;
            r_end  <= 1'b0;
            r_dout <= '0;
            for (int c = 0; c < C; c++) begin
                for (int t = 0; t < KK; t++) begin
                    r_prod[c][t] <= '0;
                end
            end
        end else if (ce) begin
            r_v1  <= w_take & w_win_vld;
            r_e1  <= w_take & w_last;
            r_vld <= r_v1;
            r_end <= r_e1;
            for (int c = 0; c < C; c++) begin
                for (int t = 0; t < KK; t++) begin
                    r_prod[c][t] <= w_prod[c][t];
                end
            end
            if (r_v1) begin
                r_dout <= w_res;
            end
        end
    end

    // A pending pulse is held through ce-low cycles and shows once ce returns.
    assign conv_dout     = r_dout;
    assign conv_dout_vld = r_vld & ce;
    assign conv_dout_end = r_end & ce;

endmodule

// File: tb/tb_depthwise_conv_stream.sv
// Bench for depthwise_conv_stream: STRIDE=1 and STRIDE=2 instances share one stimulus stream,
// both checked every cycle against a frame-level arithmetic model plus literal spot values.
module tb_depthwise_conv_stream;
    localparam int N  = 16;
    localparam int C  = 3;
    localparam int SZ = 6;
    localparam int K  = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 ce  = 1'b0;
    logic                 vin = 1'b0;
    logic [C*N-1:0]       din = '0;
    logic [C*K*K*N-1:0]   wdin = '0;
    logic [C*32-1:0]      bdin = '0;
    logic [C*5-1:0]       sdin = '0;
    logic [C*N-1:0]       dout0, dout1;
    logic                 vld0, vld1, end0, end1;

    always #5 clk = ~clk;

    depthwise_conv_stream #(.STRIDE(1)) u_s1 (
        .clk(clk), .rst_n(rst), .ce(ce), .input_vld(vin), .input_din(din),
        .weight_din(wdin), .bias_din(bdin), .shift_din(sdin),
        .conv_dout(dout0), .conv_dout_vld(vld0), .conv_dout_end(end0));

    depthwise_conv_stream #(.STRIDE(2)) u_s2 (
        .clk(clk), .rst_n(rst), .ce(ce), .input_vld(vin), .input_din(din),
        .weight_din(wdin), .bias_din(bdin), .shift_din(sdin),
        .conv_dout(dout1), .conv_dout_vld(vld1), .conv_dout_end(end1));

    typedef struct {
        logic [C*N-1:0] d;
        bit             e;
        longint         due;
    } exp_t;

    int             total = 0;
    int             bad   = 0;
    longint         en_cnt = 0;
    int             wt [C][K*K];
    int             bias [C];
    int             sh [C];
    logic [C*N-1:0] pix [SZ][SZ];
    int             mrow = 0;
    int             mcol = 0;
    int             ocnt [2];
    int             cval = 0;
    exp_t           q0[$], q1[$];
    logic [C*N-1:0] log0[$], log1[$];
    bit             loge0[$], loge1[$];

    always @(posedge clk) if (ce) en_cnt <= en_cnt + 1;

    task automatic chk(input string nm, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference: plain window arithmetic on the stored frame.
    function automatic logic [N-1:0] calc(input int ch, input int r, input int c);
        int acc;
        acc = 0;
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
                acc += int'($signed(pix[r-2+ky][c-2+kx][ch*N +: N])) * wt[ch][ky*K+kx];
        acc += bias[ch];
        acc = acc >>> sh[ch];
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return N'(acc);
    endfunction

    task automatic model_accept(input logic [C*N-1:0] d);
        exp_t e;
        int   s, os;
        if (mrow == 0 && mcol == 0) begin
            ocnt[0] = 0;
            ocnt[1] = 0;
        end
        pix[mrow][mcol] = d;
        for (int k = 0; k < 2; k++) begin
            s  = (k == 0) ? 1 : 2;
            os = (SZ - 3) / s + 1;
            if (mrow >= 2 && mcol >= 2 && (mrow - 2) % s == 0 && (mcol - 2) % s == 0) begin
                ocnt[k]++;
                for (int ch = 0; ch < C; ch++) e.d[ch*N +: N] = calc(ch, mrow, mcol);
                e.e   = (ocnt[k] == os * os);
                e.due = en_cnt + 2;
                if (k == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
        if (mcol == SZ - 1) begin
            mcol = 0;
            mrow = (mrow == SZ - 1) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
    endtask

    task automatic chk_out(input int k, input logic v, input logic [C*N-1:0] d, input logic e);
        exp_t h;
        bit   have, ev;
        have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) h = (k == 0) ? q0[0] : q1[0];
        if (have && h.due < en_cnt) begin
            chk($sformatf("missed_out_dut%0d", k), 0, 1);
            if (k == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            have = 0;
        end
        ev = have && (h.due == en_cnt) && ce;
        chk($sformatf("vld_dut%0d", k), longint'(v), longint'(ev));
        if (ev) begin
            if (k == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            if (v === 1'b1) begin
                chk($sformatf("data_dut%0d", k), longint'(d), longint'(h.d));
                chk($sformatf("end_dut%0d", k), longint'(e), longint'(h.e));
            end
        end
        if (v === 1'b1) begin
            if (k == 0) begin log0.push_back(d); loge0.push_back(e); end
            else        begin log1.push_back(d); loge1.push_back(e); end
        end
    endtask

    always @(negedge clk) begin
        chk_out(0, vld0, dout0, end0);
        chk_out(1, vld1, dout1, end1);
    end

    task automatic clr_logs();
        log0.delete(); log1.delete(); loge0.delete(); loge1.delete();
    endtask

    task automatic drive(input bit c, input bit v, input logic [C*N-1:0] d);
        @(posedge clk);
        #1;
        ce  = c;
        vin = v;
        din = d;
        if (c && v) model_accept(d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ce  = 1'b0;
        vin = 1'b0;
        q0.delete(); q1.delete();
        clr_logs();
        mrow = 0;
        mcol = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_vld", longint'(vld0 | vld1), 0);
        chk("rst_dout", longint'(dout0), 0);
        chk("rst_end", longint'(end0 | end1), 0);
    endtask

    task automatic set_w(input int mode, input int b, input int s);
        for (int c = 0; c < C; c++) begin
            for (int t = 0; t < K*K; t++) begin
                case (mode)
                    0:       wt[c][t] = 1;
                    1:       wt[c][t] = (c == 0 && t == 4) ? 1 : 0;
                    2:       wt[c][t] = 32767;
                    default: wt[c][t] = int'($urandom_range(0, 65535)) - 32768;
                endcase
                wdin[(c*K*K+t)*N +: N] = N'(wt[c][t]);
            end
            bias[c] = (mode == 3) ? int'($urandom_range(0, 4000)) - 2000 : b;
            sh[c]   = (mode == 3) ? int'($urandom_range(0, 20)) : s;
            bdin[c*32 +: 32] = bias[c];
            sdin[c*5 +: 5]   = 5'(sh[c]);
        end
    endtask

    task automatic send_frame(input bit rnd, input int mode, input int npix);
        logic [C*N-1:0] px;
        bit             cc, vv, done;
        for (int p = 0; p < npix; p++) begin
            for (int ch = 0; ch < C; ch++) begin
                case (mode)
                    0:       px[ch*N +: N] = N'(cval);
                    1:       px[ch*N +: N] = N'((p / SZ) * SZ + p % SZ);
                    default: px[ch*N +: N] = N'($urandom);
                endcase
            end
            done = 0;
            while (!done) begin
                cc = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                vv = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                drive(cc, vv, px);
                done = cc && vv;
            end
        end
    endtask

    task automatic drain();
        repeat (8) drive(1'b1, 1'b0, '0);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
    endtask

    function automatic int end_pos(input int k);
        int pos;
        pos = -1;
        if (k == 0) begin
            foreach (loge0[i]) if (loge0[i] && pos < 0) pos = i;
        end else begin
            foreach (loge1[i]) if (loge1[i] && pos < 0) pos = i;
        end
        return pos;
    endfunction

    task automatic check_centre(input string nm);
        int e1 [4];
        e1 = '{7, 9, 19, 21};
        chk({nm, "_cnt0"}, log0.size(), 16);
        foreach (log0[i]) chk({nm, "_px0"}, longint'(log0[i][N-1:0]), (i/4 + 1) * 6 + i % 4 + 1);
        chk({nm, "_cnt1"}, log1.size(), 4);
        for (int i = 0; i < log1.size() && i < 4; i++)
            chk({nm, "_px1"}, longint'(log1[i][N-1:0]), e1[i]);
        chk({nm, "_end0"}, end_pos(0), 15);
        chk({nm, "_end1"}, end_pos(1), 3);
    endtask

    initial begin
        ocnt[0] = 0;
        ocnt[1] = 0;
        do_reset();

        set_w(0, 0, 0);
        cval = 1;
        clr_logs();
        send_frame(0, 0, 36);
        drain();
        chk("s1_cnt", log0.size(), 16);
        foreach (log0[i]) chk("s1_val", longint'(log0[i]), 48'h0009_0009_0009);
        chk("s1_end", end_pos(0), 15);
        chk("s1_nend", loge0.sum() with (int'(item)), 1);

        set_w(1, 0, 0);
        clr_logs();
        send_frame(0, 1, 36);
        drain();
        check_centre("s2");

        set_w(0, 100, 2);
        cval = 4;
        clr_logs();
        send_frame(0, 0, 36);
        drain();
        chk("s3_cnt", log0.size(), 16);
        if (log0.size() > 0) chk("s3_val", longint'(log0[0]), 48'h0022_0022_0022);

        set_w(2, 0, 0);
        cval = 32'h7FFF;
        clr_logs();
        send_frame(0, 0, 36);
        drain();
        if (log0.size() > 0) chk("s4_pos_sat", longint'(log0[0][N-1:0]), 32'h7FFF);
        else                 chk("s4_pos_cnt", log0.size(), 16);
        cval = 32'h8000;
        clr_logs();
        send_frame(0, 0, 36);
        drain();
        if (log0.size() > 0) chk("s4_neg_sat", longint'(log0[15][N-1:0]), 32'h8000);
        else                 chk("s4_neg_cnt", log0.size(), 16);

        set_w(1, 0, 0);
        clr_logs();
        send_frame(1, 1, 36);
        drain();
        check_centre("s5");

        send_frame(0, 1, 20);
        do_reset();
        send_frame(0, 1, 36);
        drain();
        check_centre("s6");

        for (int f = 0; f < 3; f++) begin
            set_w(3, 0, 0);
            send_frame(1, 2, 36);
            send_frame(1, 2, 36);
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
